pipe_ctrl: RTL

Parametrised pipeline hazard controller sitting between the execute stage, interrupt controller, bus arbiter and the pc/pipeline registers. It merges N hold requests into a per-stage hold vector, turns a branch/jump into a redirect pulse plus a timed per-stage flush, and buffers a redirect that arrives while the PC stage is frozen. It also keeps a saturating stall-cycle counter and a hold-timeout watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_sat_counter.sv | 34 +++
 rtl/pipe_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and index constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_e;

    localparam int unsigned STG_PC     = 0;
    localparam int unsigned STG_IF_ID  = 1;
    localparam int unsigned STG_ID_EX  = 2;
    localparam int unsigned STG_EX_MEM = 3;

    localparam int unsigned SRC_EX    = 0;
    localparam int unsigned SRC_CLINT = 1;
    localparam int unsigned SRC_RIB   = 2;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: merges hold requests, issues redirect strobes with
// timed flushes, buffers a redirect while the PC is frozen, counts stalls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned              ADDR_W       = 32,
    parameter int unsigned              N_STAGES     = 4,
    parameter int unsigned              N_SRC        = 3,
    parameter logic [N_SRC*N_STAGES-1:0] SRC_MASK    = '1,
    parameter logic [N_STAGES-1:0]      FLUSH_MASK   = N_STAGES'(4'b0110),
    parameter int unsigned              FLUSH_CYCLES = 1,
    parameter int unsigned              CNT_W        = 32,
    parameter int unsigned              TIMEOUT      = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   jump_addr_i,
    input  logic                jump_en_i,
    input  logic [N_SRC-1:0]    hold_req_i,
    input  logic                cnt_clr_i,
    output logic [ADDR_W-1:0]   jump_addr_o,
    output logic                jump_en_o,
    output logic [N_STAGES-1:0] hold_o,
    output logic [N_STAGES-1:0] flush_o,
    output logic                pend_o,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic                hold_timeout_o
);

    localparam int unsigned TMR_W = 2;
    localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(FLUSH_CYCLES - 1);
    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [TMR_W-1:0]    flush_tmr_q, flush_tmr_d;
    logic                pend_q, pend_d;
    logic                tmo_q, tmo_d;
    logic [N_STAGES-1:0] hold_c;
    logic [WD_W-1:0]     run_cnt;

    // Per-stage hold: OR of every requesting source that is wired to that stage.
    always_comb begin
        hold_c = '0;
        for (int s = 0; s < int'(N_STAGES); s++) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                hold_c[s] = hold_c[s] | (hold_req_i[i] & SRC_MASK[i*int'(N_STAGES)+s]);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        jump_en_o   = 1'b0;
        jump_addr_o = jump_addr_i;
        case (state_q)
            RUN: begin
                if (jump_en_i) begin
                    if (!hold_c[STG_PC]) begin
                        jump_en_o = 1'b1;
                    end else begin
                        pend_addr_d = jump_addr_i;
                        state_d     = PEND;
                    end
                end
            end
            PEND: begin
                // A reset in the release cycle discards the buffered redirect.
                if (!hold_c[STG_PC] && rst_n) begin
                    jump_en_o   = 1'b1;
                    jump_addr_o = pend_addr_q;
                    state_d     = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (jump_en_o) begin
            flush_tmr_d = FLUSH_LOAD;
        end else if (flush_tmr_q != '0) begin
            flush_tmr_d = flush_tmr_q - TMR_W'(1);
        end else begin
            flush_tmr_d = '0;
        end
        flush_o = ((flush_tmr_q != '0) || jump_en_o) ? FLUSH_MASK : '0;
        pend_d  = (state_d == PEND);
    end

    // Watchdog flag: sets on the TIMEOUT-th consecutive PC hold cycle.
    always_comb begin
        tmo_d = tmo_q;
        if (cnt_clr_i) begin
            tmo_d = 1'b0;
        end else if ((TIMEOUT != 0) && hold_c[STG_PC] && (run_cnt >= WD_LIM)) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pend_addr_q <= '0;
            flush_tmr_q <= '0;
            pend_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            flush_tmr_q <= flush_tmr_d;
            pend_q      <= pend_d;
            tmo_q       <= tmo_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (hold_c[STG_PC]),
        .clr_i (cnt_clr_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(WD_W)) u_hold_run (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (hold_c[STG_PC]),
        .clr_i (cnt_clr_i | ~hold_c[STG_PC]),
        .cnt_o (run_cnt)
    );

    assign hold_o         = hold_c;
    assign pend_o         = pend_q;
    assign hold_timeout_o = tmo_q;

endmodule
